// File: rtl/payload_char_feeder_if.sv
// AXI4-Stream payload bundle between the packet source and the character feeder.
interface payload_char_feeder_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/payload_char_feeder.sv
// Serialises a packet stream into one registered character per cycle, framed by
// a start-of-data clear pulse and an end-of-data sample strobe.
module payload_char_feeder #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_BYTES  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    payload_char_feeder_if.slave  s_axis,
    input  logic                  hold_i,
    output logic                  sod_o,
    output logic                  en_o,
    output logic [7:0]            char_byte_o,
    output logic [255:0]          char_onehot_o,
    output logic                  eod_o,
    output logic [15:0]           byte_pos_o
);
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SOD, SHIFT, EOD} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [LANES-1:0]      keep_q, keep_d;
    logic                  last_q, last_d;
    logic [15:0]           pcnt_q, pcnt_d;
    logic                  sod_q, sod_d;
    logic                  en_q, en_d;
    logic                  eod_q, eod_d;
    logic [7:0]            char_q, char_d;
    logic [255:0]          onehot_q, onehot_d;
    logic [15:0]           pos_q, pos_d;

    logic [LANES-1:0]      keep_nxt;
    logic                  word_end;
    logic [16:0]           rel;
    logic                  rdy;

    // The held word shifts down one lane per byte, so lane 0 is always the next
    // character and a zero in lane 1 marks the final byte of the word.
    assign keep_nxt = keep_q >> 1;
    assign word_end = ~keep_nxt[0];
    assign rel      = {1'b0, pcnt_q} - 17'(HDR_BYTES);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        keep_d   = keep_q;
        last_d   = last_q;
        pcnt_d   = pcnt_q;
        sod_d    = 1'b0;
        en_d     = 1'b0;
        eod_d    = 1'b0;
        char_d   = char_q;
        onehot_d = '0;
        pos_d    = pos_q;
        rdy      = 1'b0;

        case (state_q)
            IDLE: rdy = 1'b1;
            SOD, SHIFT: begin
                state_d = SHIFT;
                if (!hold_i) begin
                    if (keep_q[0]) begin
                        char_d = word_q[7:0];
                        pcnt_d = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
                        if (!rel[16]) begin
                            en_d     = 1'b1;
                            pos_d    = rel[15:0];
                            onehot_d = 256'd1 << word_q[7:0];
                        end
                        word_d = word_q >> 8;
                        keep_d = word_end ? '0 : keep_nxt;
                        rdy    = word_end & ~last_q;
                    end else if (last_q) begin
                        state_d = EOD;
                        eod_d   = 1'b1;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            end
            EOD: state_d = IDLE;
        endcase

        if (rdy && s_axis.tvalid) begin
            word_d = s_axis.tdata;
            keep_d = s_axis.tkeep;
            last_d = s_axis.tlast;
            if (state_q == IDLE) begin
                state_d = SOD;
                sod_d   = 1'b1;
                pcnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            pcnt_q   <= '0;
            sod_q    <= 1'b0;
            en_q     <= 1'b0;
            eod_q    <= 1'b0;
            char_q   <= '0;
            onehot_q <= '0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
            pcnt_q   <= pcnt_d;
            sod_q    <= sod_d;
            en_q     <= en_d;
            eod_q    <= eod_d;
            char_q   <= char_d;
            onehot_q <= onehot_d;
            pos_q    <= pos_d;
        end
    end

    assign s_axis.tready = rdy & ~reset;
    assign sod_o         = sod_q;
    assign en_o          = en_q;
    assign eod_o         = eod_q;
    assign char_byte_o   = char_q;
    assign char_onehot_o = onehot_q;
    assign byte_pos_o    = pos_q;
endmodule

// File: tb/tb_payload_char_feeder.sv
// Bench for payload_char_feeder: two instances (no header / 14-byte header) share
// the stimulus and are checked against a per-packet event model.
module tb_payload_char_feeder;
    localparam int DW  = 64;
    localparam int HDR = 14;
    localparam logic [1:0] K_SOD = 2'd0, K_BYTE = 2'd1, K_EOD = 2'd2;

    typedef struct packed { logic [1:0] k; logic [7:0] b; logic [15:0] p; } ev_t;
    typedef struct packed { logic [63:0] d; logic [7:0] kp; logic l; } wd_t;

    logic clk = 1'b0, reset = 1'b1, hold = 1'b0;
    payload_char_feeder_if #(.DATA_WIDTH(DW)) ax_a ();
    payload_char_feeder_if #(.DATA_WIDTH(DW)) ax_b ();

    logic a_sod, a_en, a_eod, b_sod, b_en, b_eod;
    logic [7:0] a_ch, b_ch;
    logic [255:0] a_oh, b_oh;
    logic [15:0] a_pos, b_pos;

    payload_char_feeder #(.DATA_WIDTH(DW), .HDR_BYTES(0)) dut_a (
        .clk(clk), .reset(reset), .s_axis(ax_a), .hold_i(hold),
        .sod_o(a_sod), .en_o(a_en), .char_byte_o(a_ch), .char_onehot_o(a_oh),
        .eod_o(a_eod), .byte_pos_o(a_pos));
    payload_char_feeder #(.DATA_WIDTH(DW), .HDR_BYTES(HDR)) dut_b (
        .clk(clk), .reset(reset), .s_axis(ax_b), .hold_i(hold),
        .sod_o(b_sod), .en_o(b_en), .char_byte_o(b_ch), .char_onehot_o(b_oh),
        .eod_o(b_eod), .byte_pos_o(b_pos));

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0;
    wd_t up_q[$];
    ev_t qa[$], qb[$];
    logic [7:0] pb[$];
    int acc_log[$], sod_log[$], eod_log[$], en_log[$], rdy_log[$];
    int b_en_cnt, b_first_en, b_sod_cyc, b_eod_cyc, b_eod_cnt;
    logic first_oh50;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic [7:0] b, input logic [15:0] p);
        ev_t e;
        e.k = k; e.b = b; e.p = p;
        return e;
    endfunction

    // Upstream source: words leave the queue only on a real handshake.
    always @(posedge clk) begin
        if (ax_a.tvalid && ax_a.tready) begin
            acc_log.push_back(cyc);
            void'(up_q.pop_front());
        end
        cyc++;
        #1;
        if (up_q.size() != 0) begin
            ax_a.tvalid = 1'b1; ax_a.tdata = up_q[0].d; ax_a.tkeep = up_q[0].kp; ax_a.tlast = up_q[0].l;
        end else begin
            ax_a.tvalid = 1'b0; ax_a.tdata = '0; ax_a.tkeep = '0; ax_a.tlast = 1'b0;
        end
        ax_b.tvalid = ax_a.tvalid; ax_b.tdata = ax_a.tdata;
        ax_b.tkeep  = ax_a.tkeep;  ax_b.tlast = ax_a.tlast;
    end

    task automatic cmp(input int id, input logic s, input logic e, input logic d,
                       input logic [7:0] ch, input logic [255:0] oh, input logic [15:0] pos);
        ev_t x;
        logic [2:0] ek;
        logic [255:0] eoh;
        string t;
        bit have;
        t = (id == 0) ? "A" : "B";
        eoh = e ? (256'd1 << ch) : '0;
        if (s || e || d) begin
            have = (id == 0) ? (qa.size() != 0) : (qb.size() != 0);
            if (!have) begin
                chk({t, ".unexpected_event"}, {s, e, d}, 3'b000);
            end else begin
                if (id == 0) x = qa.pop_front();
                else         x = qb.pop_front();
                case (x.k)
                    K_SOD:   ek = 3'b100;
                    K_BYTE:  ek = 3'b010;
                    default: ek = 3'b001;
                endcase
                chk({t, ".event_kind"}, {s, e, d}, ek);
                if (e && x.k == K_BYTE) begin
                    chk({t, ".char_byte"}, ch, x.b);
                    chk({t, ".byte_pos"}, pos, x.p);
                    eoh = 256'd1 << x.b;
                end
            end
        end
        chk({t, ".char_onehot"}, oh, eoh);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp(0, a_sod, a_en, a_eod, a_ch, a_oh, a_pos);
            cmp(1, b_sod, b_en, b_eod, b_ch, b_oh, b_pos);
            chk("tready_agree", ax_b.tready, ax_a.tready);
        end
        if (a_sod) sod_log.push_back(cyc);
        if (a_eod) eod_log.push_back(cyc);
        if (ax_a.tready) rdy_log.push_back(cyc);
        if (a_en) begin
            if (en_log.size() == 0) first_oh50 = a_oh[8'h50];
            en_log.push_back(cyc);
        end
        if (b_en) begin
            b_en_cnt++;
            if (b_en_cnt == 1) b_first_en = cyc;
        end
        if (b_sod) b_sod_cyc = cyc;
        if (b_eod) begin b_eod_cyc = cyc; b_eod_cnt++; end
    end

    // Packet model: expected event stream per instance plus the word sequence.
    task automatic send_pkt();
        wd_t w;
        int n, i;
        n = pb.size();
        qa.push_back(mk(K_SOD, 8'h00, 16'h0));
        qb.push_back(mk(K_SOD, 8'h00, 16'h0));
        for (int k = 0; k < n; k++) begin
            qa.push_back(mk(K_BYTE, pb[k], 16'(k)));
            if (k >= HDR) qb.push_back(mk(K_BYTE, pb[k], 16'(k - HDR)));
        end
        qa.push_back(mk(K_EOD, 8'h00, 16'h0));
        qb.push_back(mk(K_EOD, 8'h00, 16'h0));
        i = 0;
        do begin
            w = '0;
            for (int j = 0; j < 8 && i + j < n; j++) begin
                w.d[j*8 +: 8] = pb[i+j];
                w.kp[j] = 1'b1;
            end
            i += 8;
            w.l = (i >= n);
            up_q.push_back(w);
        end while (i < n);
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        pb.delete();
        for (int k = 0; k < n; k++) pb.push_back(base + 8'(k));
    endtask

    task automatic clear_logs();
        acc_log.delete(); sod_log.delete(); eod_log.delete(); en_log.delete(); rdy_log.delete();
        b_en_cnt = 0; b_first_en = 0; b_sod_cyc = 0; b_eod_cyc = 0; b_eod_cnt = 0;
        first_oh50 = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((up_q.size() != 0 || qa.size() != 0 || qb.size() != 0) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk({nm, ".drain_in_time"}, t < 600, 1'b1);
        up_q.delete(); qa.delete(); qb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_pos(input string nm, input logic [15:0] p);
        int t = 0;
        while (!(a_en && a_pos == p) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({nm, ".reach_pos"}, t < 200, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        string s;
        int tt, n_rdy;
        clear_logs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.tready", ax_a.tready, 1'b0);
        chk("reset.outputs", {a_sod, a_en, a_eod, a_ch, a_pos}, '0);
        chk("reset.onehot", a_oh, '0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("idle.tready", ax_a.tready, 1'b1);

        // "PORT=12*Vic": full word then tkeep=0x07 with tlast
        clear_logs();
        s = "PORT=12*Vic";
        pb.delete();
        for (int k = 0; k < s.len(); k++) pb.push_back(s[k]);
        send_pkt();
        drain("t1");
        tt = acc_log[0];
        chk("t1.sod_cycle", sod_log[0], tt + 1);
        chk("t1.first_en", en_log[0], tt + 2);
        chk("t1.en_count", en_log.size(), 11);
        chk("t1.last_en", en_log[10], tt + 12);
        chk("t1.eod_cycle", eod_log[0], tt + 13);
        chk("t1.onehot50", first_oh50, 1'b1);
        chk("t1.word1_accept", acc_log[1], tt + 8);
        n_rdy = 0;
        foreach (rdy_log[k]) if (rdy_log[k] >= tt + 9 && rdy_log[k] <= tt + 13) n_rdy++;
        chk("t1.tready_low_drain", n_rdy, 0);

        // back-to-back 8 and 16 bytes, tvalid held high
        clear_logs();
        fill(8, 8'h10); send_pkt();
        fill(16, 8'h20); send_pkt();
        drain("t2");
        chk("t2.eod1", eod_log[0], sod_log[0] + 9);
        chk("t2.sod2_gap", sod_log[1], eod_log[0] + 2);
        chk("t2.eod2", eod_log[1], sod_log[1] + 17);
        chk("t2.en_count", en_log.size(), 24);
        chk("t2.pkt1_nobubble", en_log[7] - en_log[0], 7);
        chk("t2.pkt2_nobubble", en_log[23] - en_log[8], 15);
        chk("t2.accept2", sod_log[1], acc_log[1] + 1);

        // 20-byte packet seen through the 14-byte header instance
        clear_logs();
        fill(20, 8'h30); send_pkt();
        drain("t3");
        chk("t3.hdr_en_count", b_en_cnt, 6);
        chk("t3.hdr_first_en", b_first_en, sod_log[0] + 15);
        chk("t3.hdr_sod", b_sod_cyc, sod_log[0]);
        chk("t3.hdr_eod", b_eod_cyc, eod_log[0]);
        chk("t3.full_en_count", en_log.size(), 20);

        // hold for 3 cycles just before byte 5 advances
        clear_logs();
        fill(16, 8'h40); send_pkt();
        wait_pos("t4", 16'd4);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            if (k == 2) #1 hold = 1'b0;
            @(negedge clk);
            chk("t4.hold_frozen", {a_en, a_ch, a_pos}, {1'b0, 8'h44, 16'd4});
        end
        @(negedge clk);
        chk("t4.byte5_after", {a_en, a_ch, a_pos}, {1'b1, 8'h45, 16'd5});
        drain("t4");
        chk("t4.en_count", en_log.size(), 16);
        chk("t4.gap", en_log[5] - en_log[4], 4);

        // lone tlast word with tkeep=0
        clear_logs();
        pb.delete(); send_pkt();
        drain("t5");
        chk("t5.sod_eod_gap", eod_log[0] - sod_log[0], 1);
        chk("t5.no_en", en_log.size(), 0);
        chk("t5.no_en_hdr", b_en_cnt, 0);

        // reset at byte 4 of a 16-byte packet, then a fresh packet
        clear_logs();
        fill(16, 8'h60); send_pkt();
        wait_pos("t6", 16'd4);
        reset = 1'b1;
        up_q.delete();
        chk("t6.tready_in_reset", ax_a.tready, 1'b0);
        @(posedge clk); #1;
        qa.delete(); qb.delete();
        reset = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("t6.outputs_reset", {a_sod, a_en, a_eod, a_ch, a_pos}, '0);
        chk("t6.onehot_reset", a_oh, '0);
        chk("t6.tready_idle", ax_a.tready, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6.no_eod", eod_log.size() + b_eod_cnt, 0);
        fill(8, 8'h70); send_pkt();
        drain("t6b");
        chk("t6.fresh_sod", sod_log.size(), 1);
        chk("t6.fresh_en", en_log.size(), 8);
        chk("t6.fresh_eod", eod_log[0], sod_log[0] + 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
